// File: rtl/pipe_pkg.sv
// Shared types for the ID->EX stage: control-bundle layout and the occupancy states of the elastic register.
// No logic here; latency and backpressure belong to the modules that import it.
package pipe_pkg;

  localparam int CTRL_W = 8;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
  } idex_ctrl_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } stage_state_e;

endpackage

// File: rtl/pipe_skid_reg.sv
// Generic main+skid payload register with valid/ready: 1-cycle latency; SKID=1 gives a registered in_rdy_o and
// absorbs one extra word under backpressure, SKID=0 holds one word with in_rdy_o = empty | out_rdy_i.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int W    = 8,
  parameter bit SKID = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush_i,
  input  logic         in_vld_i,
  output logic         in_rdy_o,
  input  logic [W-1:0] in_dat_i,
  output logic         out_vld_o,
  input  logic         out_rdy_i,
  output logic [W-1:0] out_dat_o
);

  stage_state_e state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         acc;
  logic         cons;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // A flushed cycle never accepts; a consume in that cycle still completes for the downstream side.
  assign acc  = in_vld_i & in_rdy_o & ~flush_i;
  assign cons = out_vld_o & out_rdy_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (acc) begin
          main_d  = in_dat_i;
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (acc && cons) begin
          main_d = in_dat_i;
        end else if (acc) begin
          skid_d  = in_dat_i;
          state_d = ST_SKID;
        end else if (cons) begin
          state_d = ST_EMPTY;
        end
      end
      ST_SKID: begin
        if (cons) begin
          main_d  = skid_q;
          state_d = ST_FULL;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush_i) state_d = ST_EMPTY;
  end

  always_comb begin
    out_vld_o = (state_q != ST_EMPTY);
    out_dat_o = main_q;
    if (SKID) in_rdy_o = (state_q != ST_SKID);
    else      in_rdy_o = (state_q == ST_EMPTY) | out_rdy_i;
  end

endmodule

// File: rtl/idex_pipe_stage.sv
// ID->EX pipeline register: 1-cycle latency into an empty (or draining) stage, bubble/flush handling, stall counter.
// Backpressure: out_ready low holds the head word stable; in_ready drops once both entries are occupied (SKID=1).
module idex_pipe_stage
  import pipe_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int RD_W  = 5,
  parameter int FN_W  = 4,
  parameter bit SKID  = 1'b1,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_rs1_data,
  input  logic [XLEN-1:0]   in_rs2_data,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [FN_W-1:0]   in_funct,
  input  logic [RD_W-1:0]   in_rd,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              bubble,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [XLEN-1:0]   out_rs1_data,
  output logic [XLEN-1:0]   out_rs2_data,
  output logic [XLEN-1:0]   out_imm,
  output logic [FN_W-1:0]   out_funct,
  output logic [RD_W-1:0]   out_rd,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int W = 4*XLEN + FN_W + RD_W + CTRL_W;

  idex_ctrl_t       in_ctrl_w;
  idex_ctrl_t       head_ctrl_w;
  logic [W-1:0]     in_dat_w;
  logic [W-1:0]     out_dat_w;
  logic             out_vld_w;
  logic [CNT_W-1:0] stall_q, stall_d;

  // A bubble keeps the slot and the operands but turns the word into a NOP.
  always_comb begin
    in_ctrl_w = in_ctrl;
    if (bubble) in_ctrl_w = '0;
  end

  assign in_dat_w = {in_pc, in_rs1_data, in_rs2_data, in_imm, in_funct, in_rd, in_ctrl_w};

  pipe_skid_reg #(
    .W    (W),
    .SKID (SKID)
  ) u_reg (
    .clk       (clk),
    .reset     (reset),
    .flush_i   (flush),
    .in_vld_i  (in_valid),
    .in_rdy_o  (in_ready),
    .in_dat_i  (in_dat_w),
    .out_vld_o (out_vld_w),
    .out_rdy_i (out_ready),
    .out_dat_o (out_dat_w)
  );

  assign {out_pc, out_rs1_data, out_rs2_data, out_imm, out_funct, out_rd, head_ctrl_w} = out_dat_w;
  assign out_valid = out_vld_w;

  // Control is gated by valid so a flushed or drained slot never presents live control bits to EX.
  always_comb begin
    out_ctrl = '0;
    if (out_vld_w) out_ctrl = head_ctrl_w;
  end

  always_comb begin
    stall_d = stall_q;
    if (out_vld_w && !out_ready && (stall_q != '1)) stall_d = stall_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;

endmodule
